// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ requesters.
// Requesters are granted round-robin; the captured word is sent LSB byte
// first, one byte per TX busy rise/fall cycle.
//
// state   | meaning
// IDLE    | wait for a request while the UART is not busy
// LOAD    | drive current byte and the one-cycle load strobe
// WAIT_HI | wait for TX busy to rise, bounded by BUSY_TIMEOUT
// WAIT_LO | wait for the byte frame to finish (TX busy falls)
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 2,
  parameter int WORD_BYTES   = 2,
  parameter int LEN_W        = 2,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic [NUM_REQ-1:0]                     REQ,
  input  logic [NUM_REQ*WORD_BYTES*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ*LEN_W-1:0]               REQ_LEN,
  output logic [NUM_REQ-1:0]                     GNT,
  output logic [NUM_REQ-1:0]                     DONE,
  output logic [DATA_WIDTH-1:0]                  TX_P_DATA,
  output logic                                   TX_D_VLD,
  input  logic                                   TX_BUSY,
  output logic                                   ACTIVE,
  output logic                                   TIMEOUT_ERR,
  input  logic                                   ERR_CLR
);

  localparam int WORD_W = WORD_BYTES * DATA_WIDTH;
  localparam int SEL_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int CNT_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

  state_t                state, state_nxt;
  logic [SEL_W-1:0]      sel, sel_nxt, ptr, ptr_nxt, pick, sel_inc;
  logic [SEL_W:0]        cand;
  logic                  pick_vld;
  logic [NUM_REQ-1:0]    pick_onehot, sel_onehot;
  logic [LEN_W-1:0]      pick_len;
  logic [IDX_W-1:0]      pick_last;
  logic [WORD_W-1:0]     pick_word;
  logic [WORD_W-1:0]     word, word_nxt;
  logic [IDX_W-1:0]      last, last_nxt, idx, idx_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] cur_byte, tx_data_nxt;
  logic [NUM_REQ-1:0]    gnt_nxt, done_nxt;
  logic                  tx_vld_nxt, err_set;

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(NUM_REQ)) cand = cand - (SEL_W+1)'(NUM_REQ);
      if (!pick_vld && REQ[cand[SEL_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[SEL_W-1:0];
      end
    end
  end

  // Operand muxes: picked requester's word/length, current byte, one-hots.
  always_comb begin
    pick_len    = '0;
    pick_word   = '0;
    pick_onehot = '0;
    sel_onehot  = '0;
    cur_byte    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == SEL_W'(i)) begin
        pick_len       = REQ_LEN[i*LEN_W +: LEN_W];
        pick_word      = REQ_DATA[i*WORD_W +: WORD_W];
        pick_onehot[i] = 1'b1;
      end
      if (sel == SEL_W'(i)) sel_onehot[i] = 1'b1;
    end
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (idx == IDX_W'(b)) cur_byte = word[b*DATA_WIDTH +: DATA_WIDTH];
    end
    // a zero length still sends one byte; oversize lengths clamp to the word
    if (pick_len == '0)
      pick_last = '0;
    else if (int'(pick_len) > WORD_BYTES)
      pick_last = IDX_W'(WORD_BYTES - 1);
    else
      pick_last = IDX_W'(pick_len - LEN_W'(1));
    sel_inc = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    ptr_nxt     = ptr;
    word_nxt    = word;
    last_nxt    = last;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    gnt_nxt     = '0;
    done_nxt    = '0;
    tx_data_nxt = TX_P_DATA;
    tx_vld_nxt  = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld && !TX_BUSY) begin
          sel_nxt   = pick;
          word_nxt  = pick_word;
          last_nxt  = pick_last;
          idx_nxt   = '0;
          gnt_nxt   = pick_onehot;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        tx_data_nxt = cur_byte;
        tx_vld_nxt  = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = WAIT_HI;
      end
      WAIT_HI: begin
        if (TX_BUSY) begin
          state_nxt = WAIT_LO;
        end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // UART never acknowledged the load: abandon the rest of the word
          err_set   = 1'b1;
          done_nxt  = sel_onehot;
          ptr_nxt   = sel_inc;
          idx_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!TX_BUSY) begin
          if (idx == last) begin
            done_nxt  = sel_onehot;
            ptr_nxt   = sel_inc;
            idx_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, captured word and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      sel         <= '0;
      ptr         <= '0;
      word        <= '0;
      last        <= '0;
      idx         <= '0;
      cnt         <= '0;
      GNT         <= '0;
      DONE        <= '0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      ACTIVE      <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      ptr         <= ptr_nxt;
      word        <= word_nxt;
      last        <= last_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      GNT         <= gnt_nxt;
      DONE        <= done_nxt;
      TX_P_DATA   <= tx_data_nxt;
      TX_D_VLD    <= tx_vld_nxt;
      ACTIVE      <= (state_nxt != IDLE);
      TIMEOUT_ERR <= err_set | (TIMEOUT_ERR & ~ERR_CLR);
    end
  end

endmodule
